// File: rtl/path_query_sequencer_if.sv
// ============================================================================
// path_query_sequencer_if : driver/network bus seen by the query sequencer
// Revision 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

interface path_query_sequencer_if #(
   parameter int NUM_PATHS_DW = 32,
   parameter int NUM_QUERIES  = 3,
   parameter int TAG_W        = 12
);
   logic                              i_go;
   logic [2*TAG_W*NUM_QUERIES-1:0]    i_query_tags;
   logic                              i_list_complete;
   logic                              i_reqs_complete;
   logic                              i_stall;
   logic [NUM_PATHS_DW-1:0]           i_num_paths;
   logic                              i_num_paths_vld;
   logic                              o_clear;
   logic [TAG_W-1:0]                  o_node_tag;
   logic                              o_node_tag_vld;
   logic                              o_startnode;
   logic                              o_endnode;
   logic                              o_start_counting;
   logic                              o_busy;
   logic [NUM_PATHS_DW-1:0]           o_product;
   logic                              o_product_vld;
   logic                              o_overflow;

   modport master (
      input  i_go, i_query_tags, i_list_complete, i_reqs_complete,
             i_stall, i_num_paths, i_num_paths_vld,
      output o_clear, o_node_tag, o_node_tag_vld, o_startnode, o_endnode,
             o_start_counting, o_busy, o_product, o_product_vld, o_overflow
   );

   modport slave (
      output i_go, i_query_tags, i_list_complete, i_reqs_complete,
             i_stall, i_num_paths, i_num_paths_vld,
      input  o_clear, o_node_tag, o_node_tag_vld, o_startnode, o_endnode,
             o_start_counting, o_busy, o_product, o_product_vld, o_overflow
   );
endinterface

`default_nettype wire

// File: rtl/path_query_sequencer.sv
// ============================================================================
// path_query_sequencer : runs chained (start,end) path queries, multiplies counts
// Revision 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module path_query_sequencer #(
   parameter int NUM_PATHS_DW = 32,
   parameter int NUM_QUERIES  = 3,
   parameter int TAG_W        = 12
) (
   input  logic                   clk,
   input  logic                   rst,
   path_query_sequencer_if.master bus
);
   localparam int Q_W = $clog2(NUM_QUERIES + 1);
   localparam logic [Q_W-1:0] LAST_Q = Q_W'(NUM_QUERIES - 1);

   typedef enum logic [2:0] {
      IDLE        = 3'd0,
      CLEAR       = 3'd1,
      SET_END     = 3'd2,
      WAIT_READY  = 3'd3,
      ARM         = 3'd4,
      SEND_START  = 3'd5,
      WAIT_RESULT = 3'd6,
      DONE        = 3'd7
   } state_t;

   state_t                    state;
   state_t                    state_next;
   logic [Q_W-1:0]            q;
   logic [NUM_PATHS_DW-1:0]   acc;
   logic                      ovf;
   logic [TAG_W-1:0]          node_tag;
   logic [2*NUM_PATHS_DW-1:0] full;
   logic [TAG_W-1:0]          start_tag;
   logic [TAG_W-1:0]          end_tag;

   logic                      clear;
   logic                      tag_vld;
   logic                      startnode;
   logic                      endnode;
   logic                      start_counting;
   logic                      busy;
   logic                      product_vld;
   logic [NUM_PATHS_DW-1:0]   product;
   logic                      overflow;

   assign start_tag = bus.i_query_tags[2*TAG_W*int'(q) +: TAG_W];
   assign end_tag   = bus.i_query_tags[2*TAG_W*int'(q) + TAG_W +: TAG_W];
   assign full      = {{NUM_PATHS_DW{1'b0}}, acc} * {{NUM_PATHS_DW{1'b0}}, bus.i_num_paths};

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next     = state;
      clear          = 1'b0;
      tag_vld        = 1'b0;
      startnode      = 1'b0;
      endnode        = 1'b0;
      start_counting = 1'b0;
      busy           = 1'b1;
      product_vld    = 1'b0;
      product        = '0;
      overflow       = 1'b0;
      case (state)
         IDLE: begin
            busy = 1'b0;
            if (bus.i_go) state_next = CLEAR;
         end
         CLEAR: begin
            clear      = 1'b1;
            state_next = SET_END;
         end
         SET_END: begin
            tag_vld = 1'b1;
            endnode = 1'b1;
            if (!bus.i_stall) state_next = WAIT_READY;
         end
         WAIT_READY: begin
            if (bus.i_list_complete && bus.i_reqs_complete) state_next = ARM;
         end
         ARM: begin
            start_counting = 1'b1;
            state_next     = SEND_START;
         end
         SEND_START: begin
            tag_vld   = 1'b1;
            startnode = 1'b1;
            if (!bus.i_stall) state_next = WAIT_RESULT;
         end
         WAIT_RESULT: begin
            if (bus.i_num_paths_vld) state_next = (q == LAST_Q) ? DONE : CLEAR;
         end
         DONE: begin
            product_vld = 1'b1;
            product     = acc;
            overflow    = ovf;
            state_next  = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   // Tag is loaded one state ahead so o_node_tag never depends on inputs combinationally.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         q        <= '0;
         acc      <= NUM_PATHS_DW'(1);
         ovf      <= 1'b0;
         node_tag <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (bus.i_go) begin
                  q   <= '0;
                  acc <= NUM_PATHS_DW'(1);
                  ovf <= 1'b0;
               end
            end
            CLEAR:      node_tag <= end_tag;
            ARM:        node_tag <= start_tag;
            SET_END,
            SEND_START: if (!bus.i_stall) node_tag <= '0;
            WAIT_RESULT: begin
               if (bus.i_num_paths_vld) begin
                  acc <= full[NUM_PATHS_DW-1:0];
                  ovf <= ovf | (|full[2*NUM_PATHS_DW-1:NUM_PATHS_DW]);
                  if (q != LAST_Q) q <= q + 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   assign bus.o_clear          = clear;
   assign bus.o_node_tag       = node_tag;
   assign bus.o_node_tag_vld   = tag_vld;
   assign bus.o_startnode      = startnode;
   assign bus.o_endnode        = endnode;
   assign bus.o_start_counting = start_counting;
   assign bus.o_busy           = busy;
   assign bus.o_product        = product;
   assign bus.o_product_vld    = product_vld;
   assign bus.o_overflow       = overflow;
endmodule

`default_nettype wire

// File: tb/tb_path_query_sequencer.sv
// ============================================================================
// tb_path_query_sequencer : randomized self-checking bench with a network model
// Revision 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_path_query_sequencer;
   localparam int DW = 32;
   localparam int NQ = 3;
   localparam int TW = 12;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   path_query_sequencer_if #(.NUM_PATHS_DW(DW), .NUM_QUERIES(NQ), .TAG_W(TW)) bus ();

   path_query_sequencer #(.NUM_PATHS_DW(DW), .NUM_QUERIES(NQ), .TAG_W(TW)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int n_checks = 0;
   int n_fail   = 0;

   logic [DW-1:0] cnt   [NQ];
   logic [TW-1:0] s_tag [NQ];
   logic [TW-1:0] e_tag [NQ];

   int            n_clear, n_arm, n_prod, n_end_cyc, n_start_cyc, viol, n_starts;
   bit            arm_early, timeout;
   logic [DW-1:0] got_prod;
   logic          got_ovf;
   logic [TW-1:0] end_q[$];
   logic [TW-1:0] start_q[$];

   task automatic new_tags();
      for (int i = 0; i < NQ; i++) begin
         s_tag[i] = TW'($urandom);
         e_tag[i] = TW'($urandom);
         bus.i_query_tags[2*TW*i +: TW]      = s_tag[i];
         bus.i_query_tags[2*TW*i + TW +: TW] = e_tag[i];
      end
   endtask

   // Exact product; overflow is sticky once any running product needs more than DW bits.
   function automatic logic [DW:0] ref_product();
      logic [127:0] p;
      logic         o;
      p = 128'd1;
      o = 1'b0;
      for (int i = 0; i < NQ; i++) begin
         p = p * {96'd0, cnt[i]};
         if (p[127:DW] != 0) o = 1'b1;
      end
      return {o, p[DW-1:0]};
   endfunction

   // Plays driver + network for one job; records what the DUT did.
   task automatic run_job(input int stall_end, input int stall_start, input int reqs_low,
                          input bit go_busy, input int abort_starts);
      int cyc, pend, se, ss, post, nres;
      bit held, held_end;
      logic [TW-1:0] held_tag;
      cyc = 0; pend = 0; se = stall_end; ss = stall_start; post = 0; nres = 0;
      held = 0; held_end = 0; held_tag = '0;
      n_clear = 0; n_arm = 0; n_prod = 0; n_end_cyc = 0; n_start_cyc = 0; viol = 0; n_starts = 0;
      arm_early = 0; timeout = 0; got_prod = '0; got_ovf = 1'b0;
      end_q.delete(); start_q.delete();
      @(negedge clk);
      bus.i_go = 1'b1;
      bus.i_list_complete = 1'b1;
      bus.i_reqs_complete = (reqs_low == 0);
      while (1) begin
         @(negedge clk);
         cyc++;
         bus.i_go = 1'b0;
         bus.i_num_paths_vld = 1'b0;
         if (bus.o_clear) begin
            n_clear++;
            bus.i_num_paths_vld = 1'b1;
            bus.i_num_paths = DW'($urandom);
         end
         if (bus.o_start_counting) begin
            n_arm++;
            if (reqs_low > 0 && cyc <= reqs_low) arm_early = 1;
            if (go_busy) bus.i_go = 1'b1;
         end
         if (reqs_low > 0 && cyc == reqs_low) bus.i_reqs_complete = 1'b1;
         if (bus.o_product_vld) begin
            n_prod++;
            got_prod = bus.o_product;
            got_ovf  = bus.o_overflow;
            if (post == 0) post = 3;
         end
         if ((bus.o_node_tag_vld || bus.o_startnode || bus.o_endnode) &&
             (bus.o_clear || bus.o_start_counting)) viol++;
         if (bus.o_startnode && bus.o_endnode) viol++;
         if ((bus.o_startnode || bus.o_endnode) != bus.o_node_tag_vld) viol++;
         if ((bus.o_clear || bus.o_start_counting || bus.o_node_tag_vld || bus.o_product_vld) &&
             !bus.o_busy) viol++;
         if (pend > 0) begin
            pend--;
            if (pend == 0 && nres < NQ) begin
               bus.i_num_paths_vld = 1'b1;
               bus.i_num_paths = cnt[nres];
               nres++;
            end
         end
         bus.i_stall = 1'b0;
         if (bus.o_node_tag_vld) begin
            if (bus.o_endnode) n_end_cyc++;
            if (bus.o_startnode) n_start_cyc++;
            if (held && (bus.o_node_tag !== held_tag || bus.o_endnode !== held_end)) viol++;
            if ((bus.o_endnode && se > 0) || (bus.o_startnode && ss > 0)) begin
               bus.i_stall = 1'b1;
               if (bus.o_endnode) se--; else ss--;
               held = 1; held_tag = bus.o_node_tag; held_end = bus.o_endnode;
            end else begin
               held = 0;
               if (bus.o_endnode) begin
                  end_q.push_back(bus.o_node_tag);
                  se = stall_end;
               end else begin
                  start_q.push_back(bus.o_node_tag);
                  ss = stall_start;
                  pend = $urandom_range(1, 4);
                  n_starts++;
                  if (abort_starts > 0 && n_starts == abort_starts) break;
               end
            end
         end else begin
            bus.i_stall = 1'($urandom_range(0, 1));
         end
         if (post > 0) begin
            post--;
            if (post == 0) break;
         end
         if (cyc >= 3000) begin
            timeout = 1;
            break;
         end
      end
      bus.i_go = 1'b0;
      bus.i_stall = 1'b0;
      if (abort_starts == 0) bus.i_num_paths_vld = 1'b0;
   endtask

   task automatic test_reset();
      @(negedge clk);
      n_checks++;
      if ({bus.o_clear, bus.o_node_tag_vld, bus.o_startnode, bus.o_endnode, bus.o_start_counting,
           bus.o_product_vld, bus.o_busy, bus.o_product, bus.o_overflow, bus.o_node_tag} !== '0) begin
         n_fail++;
         $display("FAIL reset_outputs: busy=%0b clr=%0b tag=%0d product=%0d, all required 0",
                  bus.o_busy, bus.o_clear, bus.o_node_tag, bus.o_product);
      end
      rst = 1'b0;
      bus.i_num_paths_vld = 1'b1;
      bus.i_num_paths = 32'd99;
      repeat (4) @(negedge clk);
      bus.i_num_paths_vld = 1'b0;
      n_checks++;
      if (bus.o_busy !== 1'b0 || bus.o_product_vld !== 1'b0) begin
         n_fail++;
         $display("FAIL idle_ignores_vld: busy=%0b product_vld=%0b required 0 0",
                  bus.o_busy, bus.o_product_vld);
      end
   endtask

   task automatic test_basic();
      cnt[0] = 5; cnt[1] = 7; cnt[2] = 11;
      new_tags();
      run_job(0, 0, 0, 0, 0);
      n_checks++;
      if (timeout !== 0) begin n_fail++; $display("FAIL basic_timeout: got %0d required 0", timeout); end
      n_checks++;
      if (got_prod !== 32'd385 || got_ovf !== 1'b0) begin
         n_fail++; $display("FAIL basic_product: got %0d ovf %0b required 385 ovf 0", got_prod, got_ovf);
      end
      n_checks++;
      if (n_prod !== 1 || n_clear !== 3 || n_arm !== 3) begin
         n_fail++;
         $display("FAIL basic_pulses: product_vld %0d clear %0d arm %0d required 1 3 3", n_prod, n_clear, n_arm);
      end
      n_checks++;
      if (end_q.size() !== NQ || start_q.size() !== NQ) begin
         n_fail++; $display("FAIL basic_xfers: end %0d start %0d required %0d", end_q.size(), start_q.size(), NQ);
      end else begin
         for (int i = 0; i < NQ; i++) begin
            n_checks++;
            if (end_q[i] !== e_tag[i] || start_q[i] !== s_tag[i]) begin
               n_fail++;
               $display("FAIL basic_tags q%0d: end %0h start %0h required %0h %0h",
                        i, end_q[i], start_q[i], e_tag[i], s_tag[i]);
            end
         end
      end
      n_checks++;
      if (viol !== 0) begin n_fail++; $display("FAIL basic_protocol: %0d violations, required 0", viol); end
   endtask

   task automatic test_overflow();
      logic [DW:0] exp;
      cnt[0] = 32'd100000; cnt[1] = 32'd50000; cnt[2] = 32'd3;
      new_tags();
      exp = ref_product();
      run_job(0, 0, 0, 0, 0);
      n_checks++;
      if ({got_ovf, got_prod} !== exp || got_ovf !== 1'b1) begin
         n_fail++;
         $display("FAIL overflow_product: got %0d ovf %0b required %0d ovf %0b", got_prod, got_ovf, exp[DW-1:0], exp[DW]);
      end
      cnt[0] = 32'd2; cnt[1] = 32'd3; cnt[2] = 32'd1;
      run_job(0, 0, 0, 0, 0);
      n_checks++;
      if (got_prod !== 32'd6 || got_ovf !== 1'b0 || n_prod !== 1) begin
         n_fail++;
         $display("FAIL overflow_rerun: got %0d ovf %0b strobes %0d required 6 ovf 0 strobes 1", got_prod, got_ovf, n_prod);
      end
   endtask

   task automatic test_stall_start();
      cnt[0] = 3; cnt[1] = 4; cnt[2] = 2;
      new_tags();
      run_job(0, 4, 0, 0, 0);
      n_checks++;
      if (n_start_cyc !== NQ*5 || start_q.size() !== NQ || viol !== 0) begin
         n_fail++;
         $display("FAIL stall_start: cycles %0d xfers %0d viol %0d required %0d %0d 0",
                  n_start_cyc, start_q.size(), viol, NQ*5, NQ);
      end
      n_checks++;
      if (start_q.size() == NQ && (start_q[0] !== s_tag[0] || start_q[2] !== s_tag[2])) begin
         n_fail++; $display("FAIL stall_start_tag: got %0h required %0h", start_q[0], s_tag[0]);
      end
      n_checks++;
      if (got_prod !== 32'd24) begin n_fail++; $display("FAIL stall_start_product: got %0d required 24", got_prod); end
   endtask

   task automatic test_stall_end();
      cnt[0] = 10; cnt[1] = 10; cnt[2] = 10;
      new_tags();
      run_job(4, 0, 0, 0, 0);
      n_checks++;
      if (n_end_cyc !== NQ*5 || end_q.size() !== NQ || viol !== 0) begin
         n_fail++;
         $display("FAIL stall_end: cycles %0d xfers %0d viol %0d required %0d %0d 0",
                  n_end_cyc, end_q.size(), viol, NQ*5, NQ);
      end
      n_checks++;
      if (end_q.size() == NQ && (end_q[1] !== e_tag[1] || end_q[2] !== e_tag[2])) begin
         n_fail++; $display("FAIL stall_end_tag: got %0h required %0h", end_q[1], e_tag[1]);
      end
      n_checks++;
      if (got_prod !== 32'd1000) begin n_fail++; $display("FAIL stall_end_product: got %0d required 1000", got_prod); end
   endtask

   task automatic test_back_to_back();
      cnt[0] = 6; cnt[1] = 1; cnt[2] = 9;
      new_tags();
      run_job(0, 0, 10, 1, 0);
      n_checks++;
      if (arm_early !== 0) begin n_fail++; $display("FAIL reqs_wait: start_counting before reqs_complete"); end
      n_checks++;
      if (n_prod !== 1 || n_clear !== 3 || n_arm !== 3 || got_prod !== 32'd54) begin
         n_fail++;
         $display("FAIL go_while_busy: strobes %0d clear %0d arm %0d product %0d required 1 3 3 54",
                  n_prod, n_clear, n_arm, got_prod);
      end
   endtask

   task automatic test_zero_middle();
      cnt[0] = 9; cnt[1] = 0; cnt[2] = 13;
      new_tags();
      run_job(0, 0, 0, 0, 0);
      n_checks++;
      if (got_prod !== 32'd0 || got_ovf !== 1'b0 || start_q.size() !== NQ || n_arm !== NQ) begin
         n_fail++;
         $display("FAIL zero_middle: product %0d ovf %0b starts %0d arms %0d required 0 0 %0d %0d",
                  got_prod, got_ovf, start_q.size(), n_arm, NQ, NQ);
      end
   endtask

   task automatic test_random();
      logic [DW:0] exp;
      for (int it = 0; it < 10; it++) begin
         for (int i = 0; i < NQ; i++) begin
            case ($urandom_range(0, 2))
               0:       cnt[i] = DW'($urandom_range(0, 1000));
               1:       cnt[i] = DW'($urandom_range(0, 70000));
               default: cnt[i] = DW'($urandom);
            endcase
         end
         new_tags();
         exp = ref_product();
         run_job($urandom_range(0, 3), $urandom_range(0, 3), 0, 0, 0);
         n_checks++;
         if ({got_ovf, got_prod} !== exp || n_prod !== 1 || timeout !== 0) begin
            n_fail++;
            $display("FAIL random_%0d: product %0d ovf %0b strobes %0d required %0d ovf %0b strobes 1",
                     it, got_prod, got_ovf, n_prod, exp[DW-1:0], exp[DW]);
         end
         n_checks++;
         if (end_q.size() !== NQ || start_q.size() !== NQ || viol !== 0 ||
             end_q[NQ-1] !== e_tag[NQ-1] || start_q[NQ-1] !== s_tag[NQ-1]) begin
            n_fail++;
            $display("FAIL random_xfers_%0d: end %0d start %0d viol %0d", it, end_q.size(), start_q.size(), viol);
         end
      end
   endtask

   task automatic test_reset_mid();
      bit bad;
      cnt[0] = 5; cnt[1] = 6; cnt[2] = 7;
      new_tags();
      run_job(0, 0, 0, 0, 2);
      @(posedge clk);
      #1;
      n_checks++;
      if (bus.o_busy !== 1'b1) begin n_fail++; $display("FAIL mid_busy: got %0b required 1", bus.o_busy); end
      #1 rst = 1'b1;
      #1;
      n_checks++;
      if ({bus.o_clear, bus.o_node_tag_vld, bus.o_startnode, bus.o_endnode, bus.o_start_counting,
           bus.o_product_vld, bus.o_busy, bus.o_product, bus.o_overflow, bus.o_node_tag} !== '0) begin
         n_fail++;
         $display("FAIL async_reset: busy=%0b product=%0d required all 0", bus.o_busy, bus.o_product);
      end
      @(negedge clk);
      rst = 1'b0;
      bus.i_num_paths_vld = 1'b1;
      bus.i_num_paths = 32'd77;
      bad = 0;
      repeat (6) begin
         @(negedge clk);
         bus.i_num_paths_vld = 1'b0;
         if (bus.o_product_vld || bus.o_busy) bad = 1;
      end
      n_checks++;
      if (bad !== 0) begin n_fail++; $display("FAIL late_vld: DUT reacted after reset, required idle"); end
      cnt[0] = 3; cnt[1] = 4; cnt[2] = 5;
      run_job(0, 0, 0, 0, 0);
      n_checks++;
      if (got_prod !== 32'd60 || n_prod !== 1 || end_q.size() !== NQ) begin
         n_fail++;
         $display("FAIL restart_after_reset: product %0d strobes %0d required 60 1", got_prod, n_prod);
      end
   endtask

   initial begin
      bus.i_go = 1'b0;
      bus.i_query_tags = '0;
      bus.i_list_complete = 1'b1;
      bus.i_reqs_complete = 1'b1;
      bus.i_stall = 1'b0;
      bus.i_num_paths = '0;
      bus.i_num_paths_vld = 1'b0;
      test_reset();
      test_basic();
      test_overflow();
      test_stall_start();
      test_stall_end();
      test_back_to_back();
      test_zero_middle();
      test_random();
      test_reset_mid();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule

`default_nettype wire

// File: doc/path_query_sequencer.md
# path_query_sequencer

Controller that sequences the path-counting node network through a fixed list of (start, end) node queries and multiplies the per-query path counts into one result. It sits between the input driver and the node network. The driver first loads the node list. This block then owns the network's tag port, configuration pulses and result port for the counting phase. It runs NUM_QUERIES counting runs back to back, for example svr→fft, fft→dac, dac→out.

## Interface
Parameters:
- NUM_PATHS_DW, 32, width of per-query path count and of the product
- NUM_QUERIES, 3, number of chained queries (≥1)
- TAG_W, 12, node tag width

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- i_go  in  1  start pulse; honoured only in IDLE
- i_query_tags  in  2·TAG_W·NUM_QUERIES  query k occupies bits [2·TAG_W·k +: 2·TAG_W]; low TAG_W = start tag, high TAG_W = end tag
- i_list_complete  in  1  driver has finished loading the node list
- i_reqs_complete  in  1  network has no outstanding internal requests
- i_stall  in  1  network cannot accept a tag this cycle
- i_num_paths  in  NUM_PATHS_DW  path count from network
- i_num_paths_vld  in  1  i_num_paths valid (single-cycle)
- o_clear  out  1  pulse: clear network path counters and endnode flag
- o_node_tag  out  TAG_W  tag to network
- o_node_tag_vld  out  1  o_node_tag valid
- o_startnode  out  1  qualifies o_node_tag as start node
- o_endnode  out  1  qualifies o_node_tag as end node (configuration write)
- o_start_counting  out  1  pulse: arm network counting
- o_busy  out  1  high in every state except IDLE
- o_product  out  NUM_PATHS_DW  product of all query counts (truncated)
- o_product_vld  out  1  single-cycle result strobe
- o_overflow  out  1  product exceeded NUM_PATHS_DW bits; valid with o_product_vld

## Operation
- Registers:
  - query index q, width ≥ clog2(NUM_QUERIES+1)
  - accumulator acc (NUM_PATHS_DW), reset to 1 on each i_go
  - sticky ovf
- State machine (registered state):
  - IDLE: i_go → CLEAR; set q=0, acc=1, ovf=0.
  - CLEAR: o_clear=1 for one cycle → SET_END.
  - SET_END: drive o_node_tag=end(q), o_node_tag_vld=1, o_endnode=1. Hold while i_stall. Exit to WAIT_READY on the first cycle with ~i_stall.
  - WAIT_READY: wait for i_list_complete & i_reqs_complete → ARM.
  - ARM: o_start_counting=1 for one cycle → SEND_START.
  - SEND_START: drive o_node_tag=start(q), o_node_tag_vld=1, o_startnode=1. Hold while i_stall. Exit to WAIT_RESULT on the first cycle with ~i_stall.
  - WAIT_RESULT: wait for i_num_paths_vld. On that cycle:
    - full = acc × i_num_paths, 2·NUM_PATHS_DW bits.
    - acc ← full[NUM_PATHS_DW-1:0].
    - ovf ← ovf | (full[2·DW-1:DW] ≠ 0).
    - q==NUM_QUERIES-1 → DONE; else q←q+1 → CLEAR.
  - DONE: o_product_vld=1, o_product=acc, o_overflow=ovf for one cycle → IDLE.
- A zero count makes acc 0. Remaining queries still run; no early exit.
- i_num_paths_vld outside WAIT_RESULT is ignored.
- i_go outside IDLE is ignored.
- o_node_tag_vld, o_startnode and o_endnode are never high together with o_clear or o_start_counting.
- o_startnode and o_endnode are never high together.

## Timing
- Reset values (asynchronous):
  - state=IDLE, q=0, acc=1, ovf=0.
  - All strobes 0: o_clear, o_node_tag_vld, o_startnode, o_endnode, o_start_counting, o_product_vld.
  - o_busy=0, o_product=0, o_overflow=0, o_node_tag=0.
- All outputs are registered or decoded from registered state only; there are no combinational paths from inputs to outputs except none.
- i_go in cycle N → o_clear in cycle N+1, endnode write in N+2 if ~i_stall.
- Minimum cycles per query with no stalls and ready inputs: CLEAR 1 + SET_END 1 + WAIT_READY 1 + ARM 1 + SEND_START 1, plus network latency to i_num_paths_vld.
- o_product_vld occurs the cycle after the last i_num_paths_vld is accepted.
- Handshake: a tag transfer completes on a cycle with o_node_tag_vld & ~i_stall. Tag and qualifiers stay stable until it completes.
- Reset asserted mid-sequence: immediate return to IDLE, no o_product_vld. A later i_go restarts from query 0.

## Test plan
- NUM_QUERIES=3; counts 5, 7, 11; no stall → o_product=385, o_overflow=0, exactly one o_product_vld, three o_clear and three o_start_counting pulses.
- NUM_PATHS_DW=8, counts 20 and 20 → o_product=144 (400 mod 256), o_overflow=1. A following run with 2 and 3 → product 6, o_overflow=0.
- i_stall high for 4 cycles during SEND_START → start tag and o_startnode held all 4 cycles, one transfer, no duplicate. Repeat for SET_END.
- i_reqs_complete low for 10 cycles → o_start_counting only after it rises. i_go pulsed while busy has no effect.
- Middle count 0 → all 3 queries still issued, o_product=0, o_overflow=0.
- rst asserted during WAIT_RESULT of query 1 → all outputs to reset values immediately; a late i_num_paths_vld is ignored; a new i_go gives the correct product.
